// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-flip-flop based counter.
//   jk_mode_e  : JK excitation encoding {J,K}
//   jk_excite  : returns the {J,K} pair that moves a cell from cur to nxt
// -----------------------------------------------------------------------------
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_mode_e;

    // Minimal excitation: only set when rising, only reset when falling,
    // otherwise hold. TOGGLE is never requested by the counter.
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
        logic j_v;
        logic k_v;
        j_v = ~cur & nxt;
        k_v = cur & ~nxt;
        return {j_v, k_v};
    endfunction

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// Single JK flip-flop storage cell.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-low reset, cell clears to 0
//   j    in  J excitation
//   k    in  K excitation
//   q    out stored bit
// -----------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // JK state update: hold / reset / set / toggle selected by {J,K}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= 1'b0;
        end else begin
            case (jk_mode_e'({j, k}))
                HOLD:    q_r <= q_r;
                RESET:   q_r <= 1'b0;
                SET:     q_r <= 1'b1;
                TOGGLE:  q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule : jk_cell

// File: rtl/jk_counter.sv
// -----------------------------------------------------------------------------
// jk_counter
// Synchronous mod-MODULUS up/down counter; every count bit is a jk_cell whose
// J/K inputs are derived from the present and next count.
// Parameters:
//   WIDTH    count width, 2**WIDTH >= MODULUS
//   MODULUS  sequence length, 2..2**WIDTH
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-low reset
//   en    in   count enable
//   up    in   1 = increment, 0 = decrement
//   load  in   synchronous parallel load (priority over en)
//   din   in   load value, clamped to MODULUS-1
//   q     out  present count
//   tc    out  terminal count (combinational from q and up)
//   wrap  out  registered one-cycle pulse when q shows a wrapped value
// Build option:
//   JK_COUNTER_SAT_EN  saturate at the ends instead of wrapping; wrap stays 0
// -----------------------------------------------------------------------------
module jk_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] nxt_s;
    logic             wrap_nxt_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic             wrap_r;

    // Next-count selection: load (with clamp) > count > hold
    always_comb begin
        nxt_s      = q_r;
        wrap_nxt_s = 1'b0;
        if (load) begin
            // Comparing against MAX_VAL keeps the test inside WIDTH bits even
            // when MODULUS == 2**WIDTH.
            if (din > MAX_VAL) begin
                nxt_s = MAX_VAL;
            end else begin
                nxt_s = din;
            end
        end else if (en) begin
            if (up) begin
                if (q_r == MAX_VAL) begin
`ifdef JK_COUNTER_SAT_EN
                    nxt_s      = q_r;
                    wrap_nxt_s = 1'b0;
`else
                    nxt_s      = ZERO_VAL;
                    wrap_nxt_s = 1'b1;
`endif
                end else begin
                    nxt_s = q_r + ONE_VAL;
                end
            end else begin
                if (q_r == ZERO_VAL) begin
`ifdef JK_COUNTER_SAT_EN
                    nxt_s      = q_r;
                    wrap_nxt_s = 1'b0;
`else
                    nxt_s      = MAX_VAL;
                    wrap_nxt_s = 1'b1;
`endif
                end else begin
                    nxt_s = q_r - ONE_VAL;
                end
            end
        end else begin
            nxt_s      = q_r;
            wrap_nxt_s = 1'b0;
        end
    end

    // Per-bit J/K excitation; unchanged bits get J=K=0 (hold)
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            {j_s[i], k_s[i]} = jk_excite(q_r[i], nxt_s[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .j   (j_s[gi]),
                .k   (k_s[gi]),
                .q   (q_r[gi])
            );
        end
    endgenerate

    // Wrap pulse register, aligned with the wrapped value appearing on q
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_nxt_s;
        end
    end

    assign q    = q_r;
    assign wrap = wrap_r;
    assign tc   = (up && (q_r == MAX_VAL)) || (!up && (q_r == ZERO_VAL));

endmodule : jk_counter

// File: tb/tb_jk_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_counter
// Directed self-checking bench for jk_counter (WIDTH=4, MODULUS=10).
// Define JK_COUNTER_SAT_EN for both RTL and bench to exercise saturating mode.
// -----------------------------------------------------------------------------
module tb_jk_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic       wrap;

    int n_vec;
    int n_err;

    jk_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .tc   (tc),
        .wrap (wrap)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] eq,
                             input logic etc, input logic ewrap);
        check_val({tag, ".q"}, 32'(q), 32'(eq));
        check_val({tag, ".tc"}, 32'(tc), 32'(etc));
        check_val({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
    endtask

    logic [3:0] load_in  [4];
    logic [3:0] load_exp [4];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        load  = 1'b0;
        din   = 4'd0;

        // Reset state
        #12;
        check_out("rst_up", 4'd0, 1'b0, 1'b0);
        up = 1'b0;
        #1;
        check_val("rst_dn.tc", 32'(tc), 32'd1);
        up = 1'b1;
        rst = 1'b1;

        // Reach q=7, then reset asynchronously mid-count
        tick();
        load = 1'b1; din = 4'd7;
        tick();
        check_out("load7", 4'd7, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 4'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;

        // Up count from 0 for 12 edges: 1..9,0,1,2
        for (int i = 0; i < 12; i++) begin
            logic [3:0] eq;
            eq = 4'((i + 1) % 10);
            tick();
            check_out($sformatf("up%0d", i), eq, (eq == 4'd9), (i == 9));
        end

        // Down count from 0: 9,8,7 with a single wrap when 9 appears
        load = 1'b1; din = 4'd0;
        tick();
        check_out("load0", 4'd0, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        check_val("dn_tc0", 32'(tc), 32'd1);
        tick();
        check_out("dn9", 4'd9, 1'b0, 1'b1);
        tick();
        check_out("dn8", 4'd8, 1'b0, 1'b0);
        tick();
        check_out("dn7", 4'd7, 1'b0, 1'b0);

        // Load beats enable; clamp of out-of-range values
        load = 1'b1; din = 4'd5; up = 1'b1; en = 1'b1;
        tick();
        check_out("load5", 4'd5, 1'b0, 1'b0);
        load_in[0] = 4'd0;  load_exp[0] = 4'd0;
        load_in[1] = 4'd9;  load_exp[1] = 4'd9;
        load_in[2] = 4'd10; load_exp[2] = 4'd9;
        load_in[3] = 4'd15; load_exp[3] = 4'd9;
        for (int i = 0; i < 4; i++) begin
            din = load_in[i];
            tick();
            check_val($sformatf("clamp%0d", load_in[i]), 32'(q), 32'(load_exp[i]));
        end
        din = 4'd13;
        tick();
        check_out("load13", 4'd9, 1'b1, 1'b0);

`ifndef JK_COUNTER_SAT_EN
        // Wrap from 9, then a load clears the pulse
        load = 1'b0;
        tick();
        check_out("wrap_up", 4'd0, 1'b0, 1'b1);
        load = 1'b1; din = 4'd4;
        tick();
        check_out("load4", 4'd4, 1'b0, 1'b0);

        // Hold for 3 cycles, then alternate direction
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("hold%0d", i), 4'd4, 1'b0, 1'b0);
        end
        en = 1'b1; up = 1'b1;
        tick();
        check_out("dir_up", 4'd5, 1'b0, 1'b0);
        up = 1'b0;
        tick();
        check_out("dir_dn", 4'd4, 1'b0, 1'b0);
        up = 1'b1;
        tick();
        check_out("dir_up2", 4'd5, 1'b0, 1'b0);
`else
        // Saturating mode: up from 8 sticks at 9, down from 1 sticks at 0
        load = 1'b1; din = 4'd8;
        tick();
        check_out("sat_load8", 4'd8, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("sat_up%0d", i), 4'd9, 1'b1, 1'b0);
        end
        load = 1'b1; din = 4'd1;
        tick();
        check_out("sat_load1", 4'd1, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_out($sformatf("sat_dn%0d", i), 4'd0, 1'b1, 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_jk_counter
